// File: rtl/wrap_field_counter_pkg.sv
// Shared clock-field definitions: mode enum, field limits
// and the month-length lookup used to drive a day field's limit.
package clock_pkg;

    typedef enum logic {
        COUNT = 1'b0,
        ADJ   = 1'b1
    } mode_e;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int MON_MAX  = 12;
    localparam int DAY_MAX  = 31;

    // Days in a month (1..12); out-of-range months report 31.
    function automatic logic [6:0] month_days(
        input logic [3:0] month,
        input logic       leap
    );
        logic [6:0] d;
        d = 7'd31;
        case (month)
            4'd2:    d = leap ? 7'd29 : 7'd28;
            4'd4,
            4'd6,
            4'd9,
            4'd11:   d = 7'd30;
            default: d = 7'd31;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/wrap_field_counter_bin2bcd.sv
// Combinational binary to two-digit BCD for values 0..99.
// Shared by the field counters and the year display path.
module bin2bcd #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [3:0]       tens_o,
    output logic [3:0]       ones_o
);

    logic [WIDTH-1:0] tens_w;
    logic [WIDTH-1:0] ones_w;

    // Divide by constant ten; quotient and remainder fit in a digit.
    always_comb begin
        tens_w = bin_i / WIDTH'(10);
        ones_w = bin_i % WIDTH'(10);
    end

    assign tens_o = 4'(tens_w);
    assign ones_o = 4'(ones_w);

endmodule

// File: rtl/wrap_field_counter.sv
// Wrap-around clock field with carry chaining, button adjust,
// synchronous load and an optional run-time upper limit.
module wrap_field_counter
    import clock_pkg::*;
#(
    parameter int WIDTH      = 7,
    parameter int MIN_VAL    = 1,
    parameter int MAX_VAL    = 12,
    parameter int RST_VAL    = 1,
    parameter bit DYN_MAX_EN = 1'b0
) (
    input  logic             clk_1Hz,
    input  logic             rst_n,
    input  logic             en_1,
    input  logic             carry_in,
    input  logic             adjust,
    input  logic             up,
    input  logic             down,
    input  logic [WIDTH-1:0] max_dyn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             carry_out,
    output logic             at_max,
    output logic             adj_active
);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

    if (!(MIN_VAL <= RST_VAL && RST_VAL <= MAX_VAL &&
          MAX_VAL <= 99 && MAX_VAL < 2**WIDTH)) begin : g_bad_cfg
        $fatal(1, "wrap_field_counter: illegal MIN/RST/MAX/WIDTH");
    end

    mode_e            state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             carry_q, carry_d;
    logic             up_q, down_q;
    logic [WIDTH-1:0] dyn_lim;
    logic [WIDTH-1:0] eff_max;
    logic [WIDTH-1:0] load_clamp;
    logic             up_p, dn_p;

    // Effective limit: static, or max_dyn kept inside the static range.
    always_comb begin
        if (max_dyn < MIN_W)
            dyn_lim = MIN_W;
        else if (max_dyn > MAX_W)
            dyn_lim = MAX_W;
        else
            dyn_lim = max_dyn;
        eff_max = DYN_MAX_EN ? dyn_lim : MAX_W;
    end

    // Loaded values are forced into the currently legal range.
    always_comb begin
        if (load_val < MIN_W)
            load_clamp = MIN_W;
        else if (load_val > eff_max)
            load_clamp = eff_max;
        else
            load_clamp = load_val;
    end

    assign up_p = up & ~up_q;
    assign dn_p = down & ~down_q;

    // Mode tracking plus one prioritised value action per cycle.
    always_comb begin
        state_d = adjust ? ADJ : COUNT;
        value_d = value_q;
        carry_d = 1'b0;
        if (load) begin
            value_d = load_clamp;
        end else if (state_q == ADJ) begin
            if (up_p && !dn_p)
                value_d = (value_q >= eff_max) ? MIN_W : value_q + 1'b1;
            else if (dn_p && !up_p)
                value_d = (value_q <= MIN_W) ? eff_max : value_q - 1'b1;
        end else if (en_1 && carry_in) begin
            if (value_q >= eff_max) begin
                value_d = MIN_W;
                carry_d = 1'b1;
            end else begin
                value_d = value_q + 1'b1;
            end
        end else if (value_q > eff_max) begin
            value_d = eff_max;
        end
    end

    // State registers; buttons reset high so a held press never steps.
    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COUNT;
            value_q <= RST_W;
            carry_q <= 1'b0;
            up_q    <= 1'b1;
            down_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            carry_q <= carry_d;
            up_q    <= up;
            down_q  <= down;
        end
    end

    assign value      = value_q;
    assign carry_out  = carry_q;
    assign at_max     = (value_q == eff_max);
    assign adj_active = (state_q == ADJ);

    bin2bcd #(
        .WIDTH (WIDTH)
    ) u_bcd (
        .bin_i  (value_q),
        .tens_o (bcd_tens),
        .ones_o (bcd_ones)
    );

endmodule

// File: tb/tb_wrap_field_counter.sv
// Directed bench for wrap_field_counter: month, day (dynamic
// limit) and seconds configurations sharing one stimulus bus.
module tb_wrap_field_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_1, carry_in, adjust, up, down, load;
    logic [6:0] max_dyn, load_val;

    logic [6:0] m_val, d_val, s_val;
    logic [3:0] m_t, m_o, d_t, d_o, s_t, s_o;
    logic       m_c, d_c, s_c, m_mx, d_mx, s_mx, m_a, d_a, s_a;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wrap_field_counter #(.WIDTH(7), .MIN_VAL(1), .MAX_VAL(12),
        .RST_VAL(1), .DYN_MAX_EN(1'b0)) u_mon (
        .clk_1Hz(clk), .rst_n(rst_n), .en_1(en_1),
        .carry_in(carry_in), .adjust(adjust), .up(up),
        .down(down), .max_dyn(max_dyn), .load(load),
        .load_val(load_val), .value(m_val), .bcd_tens(m_t),
        .bcd_ones(m_o), .carry_out(m_c), .at_max(m_mx),
        .adj_active(m_a));

    wrap_field_counter #(.WIDTH(7), .MIN_VAL(1), .MAX_VAL(31),
        .RST_VAL(1), .DYN_MAX_EN(1'b1)) u_day (
        .clk_1Hz(clk), .rst_n(rst_n), .en_1(en_1),
        .carry_in(carry_in), .adjust(adjust), .up(up),
        .down(down), .max_dyn(max_dyn), .load(load),
        .load_val(load_val), .value(d_val), .bcd_tens(d_t),
        .bcd_ones(d_o), .carry_out(d_c), .at_max(d_mx),
        .adj_active(d_a));

    wrap_field_counter #(.WIDTH(7), .MIN_VAL(0), .MAX_VAL(59),
        .RST_VAL(0), .DYN_MAX_EN(1'b0)) u_sec (
        .clk_1Hz(clk), .rst_n(rst_n), .en_1(en_1),
        .carry_in(carry_in), .adjust(adjust), .up(up),
        .down(down), .max_dyn(max_dyn), .load(load),
        .load_val(load_val), .value(s_val), .bcd_tens(s_t),
        .bcd_ones(s_o), .carry_out(s_c), .at_max(s_mx),
        .adj_active(s_a));

    typedef struct {
        logic       ld;
        logic [6:0] lv;
        logic       ci;
        logic       en;
        logic       adj;
        logic       u;
        logic       d;
        int         ev;
        int         ec;
        int         ea;
        int         em;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic ld, input int lv, input logic ci,
                       input logic adj, input logic u, input logic d,
                       input int ev, input int ec, input int ea);
        vec_t v;
        v.ld = ld; v.lv = 7'(lv); v.ci = ci; v.en = 1'b1;
        v.adj = adj; v.u = u; v.d = d;
        v.ev = ev; v.ec = ec; v.ea = ea; v.em = (ev == 12) ? 1 : 0;
        vq.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; en_1 = 1'b0; carry_in = 1'b0; adjust = 1'b0;
        up = 1'b1; down = 1'b0; load = 1'b0; load_val = 7'd0;
        max_dyn = 7'd31;

        // month table: count to 12, wrap, loads, adjust corners
        for (int i = 2; i <= 12; i++) add(0, 0, 1, 0, 0, 0, i, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 40, 0, 0, 0, 0, 12, 0, 0);
        add(1, 12, 1, 0, 0, 0, 12, 0, 0);
        add(1, 11, 0, 0, 0, 0, 11, 0, 0);
        add(0, 0, 1, 1, 0, 0, 12, 0, 1);
        add(0, 0, 1, 1, 0, 0, 12, 0, 1);
        add(0, 0, 0, 1, 1, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 1, 12, 0, 1);
        add(0, 0, 0, 1, 0, 0, 12, 0, 1);
        add(0, 0, 0, 1, 1, 1, 12, 0, 1);
        add(0, 0, 0, 1, 0, 0, 12, 0, 1);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 1, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0);

        // reset values with up held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mon_val", int'(m_val), 1);
        chk("rst_mon_carry", int'(m_c), 0);
        chk("rst_mon_adj", int'(m_a), 0);
        chk("rst_sec_val", int'(s_val), 0);
        chk("rst_mon_bcd", int'({m_t, m_o}), 8'h01);
        rst_n = 1'b1;

        // held button across reset release must not step
        adjust = 1'b1;
        step();
        chk("hold_adj", int'(m_a), 1);
        chk("hold_val1", int'(m_val), 1);
        step();
        chk("hold_val2", int'(m_val), 1);
        up = 1'b0; adjust = 1'b0;
        step();
        step();

        foreach (vq[i]) begin
            load = vq[i].ld; load_val = vq[i].lv;
            carry_in = vq[i].ci; en_1 = vq[i].en;
            adjust = vq[i].adj; up = vq[i].u; down = vq[i].d;
            step();
            chk($sformatf("vec%0d_val", i), int'(m_val), vq[i].ev);
            chk($sformatf("vec%0d_carry", i), int'(m_c), vq[i].ec);
            chk($sformatf("vec%0d_adj", i), int'(m_a), vq[i].ea);
            chk($sformatf("vec%0d_atmax", i), int'(m_mx), vq[i].em);
        end
        load = 1'b0; carry_in = 1'b0; adjust = 1'b0;
        up = 1'b0; down = 1'b0;

        // asynchronous reset in the middle of adjusting
        load = 1'b1; load_val = 7'd7;
        step();
        load = 1'b0; adjust = 1'b1;
        step();
        chk("midadj_val", int'(m_val), 7);
        chk("midadj_adj", int'(m_a), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_val", int'(m_val), 1);
        chk("async_rst_adj", int'(m_a), 0);
        step();
        adjust = 1'b0;
        rst_n = 1'b1;
        step();

        // day field following a shrinking limit
        max_dyn = 7'd31; load = 1'b1; load_val = 7'd31;
        step();
        chk("day_load31", int'(d_val), 31);
        chk("day_atmax31", int'(d_mx), 1);
        load = 1'b0; max_dyn = 7'd30;
        step();
        chk("day_clamp30", int'(d_val), 30);
        chk("day_clamp_carry", int'(d_c), 0);
        max_dyn = 7'd28;
        step();
        chk("day_clamp28", int'(d_val), 28);
        chk("day_atmax28", int'(d_mx), 1);
        carry_in = 1'b1;
        step();
        chk("day_wrap_val", int'(d_val), 1);
        chk("day_wrap_carry", int'(d_c), 1);
        carry_in = 1'b0;
        step();
        chk("day_carry_drop", int'(d_c), 0);
        max_dyn = 7'd127; load = 1'b1; load_val = 7'd40;
        step();
        chk("day_dyn_hi_clamp", int'(d_val), 31);
        load = 1'b0; max_dyn = 7'd0;
        step();
        chk("day_dyn_lo_clamp", int'(d_val), 1);
        max_dyn = 7'd31;

        // seconds field: enable gating, BCD and 59 -> 0 wrap
        load = 1'b1; load_val = 7'd5;
        step();
        load = 1'b0; en_1 = 1'b0; carry_in = 1'b1;
        step();
        chk("sec_en_off", int'(s_val), 5);
        carry_in = 1'b0; en_1 = 1'b1; load = 1'b1; load_val = 7'd59;
        step();
        chk("sec_val59", int'(s_val), 59);
        chk("sec_tens59", int'(s_t), 5);
        chk("sec_ones59", int'(s_o), 9);
        chk("sec_atmax", int'(s_mx), 1);
        load = 1'b0; carry_in = 1'b1;
        step();
        chk("sec_wrap_val", int'(s_val), 0);
        chk("sec_wrap_bcd", int'({s_t, s_o}), 0);
        chk("sec_wrap_carry", int'(s_c), 1);
        carry_in = 1'b0;
        step();
        chk("sec_carry_drop", int'(s_c), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
